icache: RTL and testbench

Direct-mapped instruction cache between the fetch unit and the memory controller. Serves 32-bit instruction fetches from 128-bit (16-byte) lines. On a miss it issues a line-fill request on the memory controller's fetch port (`fc_valid`/`fc_addr` → `fc_done`/`fc_line`), installs the returned line and then answers the fetch. It is the requesting end of that fetch port; the memory controller is the responder.

---
 rtl/icache.sv | 151 +++++++++++++++
 tb/tb_icache.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped instruction cache: 32-bit fetches served from 16-byte lines,
// misses refilled over the memory controller's fetch port.
module icache #(
    parameter int IDX_BITS = 4,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              ic_rb,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_inst,
    output logic              fc_valid,
    output logic [ADDR_W-1:0] fc_addr,
    input  logic              fc_done,
    input  logic [127:0]      fc_line
);

    localparam int LINES = 1 << IDX_BITS;
    localparam int TAG_W = ADDR_W - IDX_BITS - 4;

    typedef enum logic {S_IDLE, S_MISS} state_t;

    // Word w of a line sits at bits [32w+31:32w].
    function automatic logic [31:0] word_sel(input logic [127:0] line, input logic [1:0] sel);
        case (sel)
            2'd0:    return line[31:0];
            2'd1:    return line[63:32];
            2'd2:    return line[95:64];
            default: return line[127:96];
        endcase
    endfunction

    state_t              r_state, w_state_nxt;
    logic                r_pend, w_pend_nxt;
    logic                r_fc_valid, w_fc_valid_nxt;
    logic [ADDR_W-5:0]   r_line, w_line_nxt;
    logic [1:0]          r_wsel;
    logic                r_if_done, w_if_done_nxt;
    logic [31:0]         r_if_inst, w_if_inst_nxt;
    logic                w_fill, w_launch;

    logic [LINES-1:0]    r_valid;
    logic [TAG_W-1:0]    r_tag  [LINES];
    logic [127:0]        r_data [LINES];

    logic [IDX_BITS-1:0] w_idx, w_fill_idx;
    logic [TAG_W-1:0]    w_tag;
    logic                w_hit;
    logic                w_unused;

    assign w_idx      = if_addr[IDX_BITS+3:4];
    assign w_tag      = if_addr[ADDR_W-1:IDX_BITS+4];
    assign w_fill_idx = r_line[IDX_BITS-1:0];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_unused   = ^if_addr[1:0];

    assign if_done  = r_if_done;
    assign if_inst  = r_if_inst;
    assign fc_valid = r_fc_valid;
    assign fc_addr  = {r_line, 4'b0000};

    // Next-state and output decisions; the lookup is skipped the cycle an
    // answer is out so a still-held request is not answered twice.
    always_comb begin
        w_state_nxt    = r_state;
        w_pend_nxt     = r_pend;
        w_fc_valid_nxt = r_fc_valid;
        w_line_nxt     = r_line;
        w_if_done_nxt  = 1'b0;
        w_if_inst_nxt  = r_if_inst;
        w_fill         = 1'b0;
        w_launch       = 1'b0;
        if (rdy) begin
            case (r_state)
                S_IDLE: begin
                    if (if_valid && !ic_rb && !r_if_done) begin
                        if (w_hit) begin
                            w_if_done_nxt = 1'b1;
                            w_if_inst_nxt = word_sel(r_data[w_idx], if_addr[3:2]);
                        end else begin
                            w_launch       = 1'b1;
                            w_line_nxt     = if_addr[ADDR_W-1:4];
                            w_fc_valid_nxt = 1'b1;
                            w_pend_nxt     = 1'b1;
                            w_state_nxt    = S_MISS;
                        end
                    end
                end
                S_MISS: begin
                    if (ic_rb) begin
                        w_pend_nxt = 1'b0;
                    end
                    if (fc_done) begin
                        w_fill         = 1'b1;
                        w_fc_valid_nxt = 1'b0;
                        w_pend_nxt     = 1'b0;
                        w_state_nxt    = S_IDLE;
                        if (r_pend && !ic_rb) begin
                            w_if_done_nxt = 1'b1;
                            w_if_inst_nxt = word_sel(fc_line, r_wsel);
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_pend     <= 1'b0;
            r_fc_valid <= 1'b0;
            r_line     <= '0;
            r_if_done  <= 1'b0;
            r_if_inst  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pend     <= w_pend_nxt;
            r_fc_valid <= w_fc_valid_nxt;
            r_line     <= w_line_nxt;
            r_if_done  <= w_if_done_nxt;
            r_if_inst  <= w_if_inst_nxt;
        end
    end

    // Line valid bits: cleared on reset, set when a fill lands.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[w_fill_idx] <= 1'b1;
        end
    end

    // Tag/data arrays and the latched word select are never reset.
    always_ff @(posedge clk) begin
        if (rst && w_fill) begin
            r_data[w_fill_idx] <= fc_line;
            r_tag[w_fill_idx]  <= r_line[ADDR_W-5:IDX_BITS];
        end
        if (rst && w_launch) begin
            r_wsel <= if_addr[3:2];
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus random fetches,
// checked against an array-of-lines model and a lazily randomised memory.
module tb_icache;

    localparam int IDX_BITS = 4;
    localparam int ADDR_W   = 32;
    localparam int LINES    = 1 << IDX_BITS;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rdy = 1'b1;
    logic         ic_rb = 1'b0;
    logic         if_valid = 1'b0;
    logic [31:0]  if_addr = '0;
    logic         fc_done = 1'b0;
    logic [127:0] fc_line = '0;
    logic         if_done;
    logic [31:0]  if_inst;
    logic         fc_valid;
    logic [31:0]  fc_addr;

    int total = 0;
    int bad   = 0;

    bit           mvalid [LINES];
    logic [31:0]  mtag   [LINES];
    logic [127:0] mdata  [LINES];
    logic [127:0] mem    [int unsigned];

    icache #(.IDX_BITS(IDX_BITS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .ic_rb(ic_rb),
        .if_valid(if_valid), .if_addr(if_addr),
        .if_done(if_done), .if_inst(if_inst),
        .fc_valid(fc_valid), .fc_addr(fc_addr),
        .fc_done(fc_done), .fc_line(fc_line)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] get_line(input logic [31:0] la);
        if (!mem.exists(la)) mem[la] = {$urandom, $urandom, $urandom, $urandom};
        return mem[la];
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'(a[IDX_BITS+3:4]);
    endfunction

    function automatic logic [31:0] m_tag(input logic [31:0] a);
        return a >> (IDX_BITS + 4);
    endfunction

    function automatic logic [31:0] word_of(input logic [127:0] line, input logic [31:0] a);
        logic [127:0] sh;
        sh = line >> (32 * int'(a[3:2]));
        return sh[31:0];
    endfunction

    function automatic void install(input logic [31:0] a, input logic [127:0] line);
        mvalid[m_idx(a)] = 1'b1;
        mtag[m_idx(a)]   = m_tag(a);
        mdata[m_idx(a)]  = line;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete fetch: predicted hit or miss, fill after lat cycles,
    // then the request is held one extra cycle to check for a repeat answer.
    task automatic do_fetch(input logic [31:0] a, input int lat);
        int          i;
        bit          hit;
        logic [31:0] la;
        i   = m_idx(a);
        hit = mvalid[i] && (mtag[i] == m_tag(a));
        la  = {a[31:4], 4'h0};
        if_valid = 1'b1;
        if_addr  = a;
        tick();
        if (hit) begin
            chk("hit_done", 32'(if_done), 32'd1);
            chk("hit_inst", if_inst, word_of(mdata[i], a));
            chk("hit_fcv", 32'(fc_valid), 32'd0);
        end else begin
            chk("miss_done", 32'(if_done), 32'd0);
            chk("miss_fcv", 32'(fc_valid), 32'd1);
            chk("miss_fca", fc_addr, la);
            for (int k = 0; k < lat; k++) begin
                tick();
                chk("wait_fcv", 32'(fc_valid), 32'd1);
                chk("wait_fca", fc_addr, la);
                chk("wait_done", 32'(if_done), 32'd0);
            end
            fc_line = get_line(la);
            fc_done = 1'b1;
            tick();
            fc_done = 1'b0;
            install(a, fc_line);
            chk("fill_done", 32'(if_done), 32'd1);
            chk("fill_inst", if_inst, word_of(fc_line, a));
            chk("fill_fcv", 32'(fc_valid), 32'd0);
        end
        tick();
        chk("held_done", 32'(if_done), 32'd0);
        chk("held_fcv", 32'(fc_valid), 32'd0);
        if_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        model_reset();
        mem[32'h0000_1000] = {$urandom, $urandom, 32'h0051_0093, $urandom};

        // Reset state
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_done", 32'(if_done), 32'd0);
        chk("rst_inst", if_inst, 32'd0);
        chk("rst_fcv", 32'(fc_valid), 32'd0);
        chk("rst_fca", fc_addr, 32'd0);
        rst = 1'b1;
        tick();

        // Cold miss, then hit in the same line
        do_fetch(32'h0000_1004, 2);
        chk("cold_word", if_inst, 32'h0051_0093);
        chk("cold_fca", fc_addr, 32'h0000_1000);
        do_fetch(32'h0000_100C, 0);

        // Conflict eviction: same index, different tag
        do_fetch(32'h0000_2000, 1);
        do_fetch(32'h0000_1000, 0);

        // Rollback mid-miss: line installed, no answer
        if_valid = 1'b1;
        if_addr  = 32'h0000_3000;
        tick();
        chk("rb_fcv", 32'(fc_valid), 32'd1);
        if_valid = 1'b0;
        ic_rb    = 1'b1;
        tick();
        ic_rb = 1'b0;
        chk("rb_done0", 32'(if_done), 32'd0);
        chk("rb_fcv_held", 32'(fc_valid), 32'd1);
        fc_line = get_line(32'h0000_3000);
        fc_done = 1'b1;
        tick();
        fc_done = 1'b0;
        install(32'h0000_3000, fc_line);
        chk("rb_done1", 32'(if_done), 32'd0);
        chk("rb_fcv_low", 32'(fc_valid), 32'd0);
        tick();
        chk("rb_done2", 32'(if_done), 32'd0);
        do_fetch(32'h0000_3000, 0);

        // Rollback coinciding with the fill
        if_valid = 1'b1;
        if_addr  = 32'h0000_5008;
        tick();
        chk("rbf_fcv", 32'(fc_valid), 32'd1);
        if_valid = 1'b0;
        ic_rb    = 1'b1;
        fc_line  = get_line(32'h0000_5000);
        fc_done  = 1'b1;
        tick();
        ic_rb   = 1'b0;
        fc_done = 1'b0;
        install(32'h0000_5008, fc_line);
        chk("rbf_done", 32'(if_done), 32'd0);
        chk("rbf_fcv", 32'(fc_valid), 32'd0);
        do_fetch(32'h0000_5008, 0);

        // Reset mid-miss, then a stray fill response
        if_valid = 1'b1;
        if_addr  = 32'h0000_4000;
        tick();
        chk("rmm_fcv", 32'(fc_valid), 32'd1);
        if_valid = 1'b0;
        rst      = 1'b0;
        tick();
        rst = 1'b1;
        model_reset();
        chk("rmm_fcv0", 32'(fc_valid), 32'd0);
        chk("rmm_done0", 32'(if_done), 32'd0);
        fc_line = get_line(32'h0000_4000);
        fc_done = 1'b1;
        tick();
        fc_done = 1'b0;
        chk("stray_done", 32'(if_done), 32'd0);
        chk("stray_fcv", 32'(fc_valid), 32'd0);
        tick();
        chk("stray_done2", 32'(if_done), 32'd0);
        do_fetch(32'h0000_1008, 1);

        // Stall during MISS
        if_valid = 1'b1;
        if_addr  = 32'h0000_6004;
        tick();
        chk("stall_fcv", 32'(fc_valid), 32'd1);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_fcv_held", 32'(fc_valid), 32'd1);
            chk("stall_fca_held", fc_addr, 32'h0000_6000);
            chk("stall_done", 32'(if_done), 32'd0);
        end
        rdy     = 1'b1;
        fc_line = get_line(32'h0000_6000);
        fc_done = 1'b1;
        tick();
        fc_done = 1'b0;
        install(32'h0000_6004, fc_line);
        chk("stall_ans_done", 32'(if_done), 32'd1);
        chk("stall_ans_inst", if_inst, word_of(fc_line, 32'h0000_6004));
        chk("stall_ans_fcv", 32'(fc_valid), 32'd0);
        tick();
        chk("stall_held", 32'(if_done), 32'd0);
        if_valid = 1'b0;

        // Random fetches over a small set of tags to mix hits and conflicts
        for (int n = 0; n < 80; n++) begin
            a = 32'h0001_0000 | (32'($urandom_range(0, 3)) << (IDX_BITS + 4))
                | (32'($urandom_range(0, LINES - 1)) << 4) | 32'($urandom_range(0, 15));
            do_fetch(a, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
